// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode decoupling FIFO carrying {pc, inst} pairs.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   flush_i                   drop every queued entry and any same-cycle push/pop
//   in_valid_i / in_ready_o   fetch-side handshake; pc_i / inst_i are the payload
//   out_valid_o / out_ready_i decode-side handshake; pc_o / inst_o show the head
//                             (zero-filled NOP bubble while empty)
//   count_o                   current occupancy
//
// All outputs depend on registered state only. in_ready_o stays low for
// BOOT_BUBBLES cycles after reset release.
module if_id_queue #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BOOT_BUBBLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          inst_i,
  input  logic [ADDR_W-1:0]          pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [3:0]        boot_q, boot_d;

  logic push, pop;

  assign in_ready_o  = (boot_q == 4'd0) && (count_q != CntW'(DEPTH));
  assign out_valid_o = (count_q != '0);

  // Flush wins over both handshakes.
  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    boot_d   = boot_q;

    // Boot counter only reloads on reset, so flush does not touch it.
    if (boot_q != 4'd0) begin
      boot_d = boot_q - 4'd1;
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      boot_q   <= 4'(BOOT_BUBBLES);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      boot_q   <= boot_d;
    end
  end

  // Storage is deliberately not reset; count_q gates what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pc_i, inst_i};
    end
  end

  always_comb begin
    pc_o   = '0;
    inst_o = '0;
    if (out_valid_o) begin
      {pc_o, inst_o} = mem_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;

endmodule
